// File: rtl/led_pkg.sv
// Constants shared by the colour sequencer and the RGB PWM driver.
package led_pkg;

  localparam int RED_BIT       = 2;
  localparam int GREEN_BIT     = 1;
  localparam int BLUE_BIT      = 0;
  localparam int DEF_PWM_WIDTH = 8;
  localparam int DEF_FADE_DIV  = 4;

  function automatic logic chan_on(input logic [2:0] colour, input logic enable, input int idx);
    return enable & colour[idx];
  endfunction

endpackage

// File: rtl/rgb_pwm_driver_if.sv
// Colour request in, LED pins and fade status out.
interface rgb_pwm_driver_if;
  logic [2:0] colour;
  logic       enable;
  logic       led_r;
  logic       led_g;
  logic       led_b;
  logic       busy;

  modport master (output colour, enable, input led_r, led_g, led_b, busy);
  modport slave  (input colour, enable, output led_r, led_g, led_b, busy);
endinterface

// File: rtl/pwm_channel.sv
// One LED channel: duty register that ramps toward full/off, and a registered PWM comparator.
module pwm_channel #(
  parameter int PWM_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tick,
  input  logic                 target_on,
  input  logic [PWM_WIDTH-1:0] pwm_cnt,
  output logic                 pin,
  output logic                 at_target
);

  localparam logic [PWM_WIDTH-1:0] MAX  = {PWM_WIDTH{1'b1}};
  localparam logic [PWM_WIDTH-1:0] ZERO = {PWM_WIDTH{1'b0}};
  localparam logic [PWM_WIDTH-1:0] ONE  = PWM_WIDTH'(1);

  logic [PWM_WIDTH-1:0] duty_r;
  logic [PWM_WIDTH-1:0] duty_nxt_s;
  logic [PWM_WIDTH-1:0] target_s;
  logic                 pin_r;

  assign target_s  = target_on ? MAX : ZERO;
  assign at_target = (duty_r == target_s);
  assign pin       = pin_r;

  // Single step toward the target on tick; target is only ever 0 or MAX, so no overshoot.
  always_comb begin
    duty_nxt_s = duty_r;
    if (tick && (duty_r < target_s)) begin
      duty_nxt_s = duty_r + ONE;
    end else if (tick && (duty_r > target_s)) begin
      duty_nxt_s = duty_r - ONE;
    end else begin
      duty_nxt_s = duty_r;
    end
  end

  // Duty state and registered pin drive.
  always_ff @(posedge clk) begin
    if (rst) begin
      duty_r <= ZERO;
      pin_r  <= 1'b0;
    end else begin
      duty_r <= duty_nxt_s;
      pin_r  <= (duty_r > pwm_cnt);
    end
  end

endmodule

// File: rtl/rgb_pwm_driver.sv
// RGB LED driver: registers the colour request, runs the shared PWM/fade timebase, and fans out to three channels.
module rgb_pwm_driver
  import led_pkg::*;
#(
  parameter int PWM_WIDTH = DEF_PWM_WIDTH,
  parameter int FADE_DIV  = DEF_FADE_DIV
) (
  input logic               clk,
  input logic               rst,
  rgb_pwm_driver_if.slave   bus
);

  localparam int                 DIV_W    = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;
  localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(FADE_DIV - 1);

  logic [2:0]           colour_q_r;
  logic                 enable_q_r;
  logic [PWM_WIDTH-1:0] pwm_cnt_r;
  logic [DIV_W-1:0]     div_cnt_r;
  logic                 tick_s;
  logic                 led_r_s, led_g_s, led_b_s;
  logic                 at_r_s, at_g_s, at_b_s;

  assign tick_s = (div_cnt_r == DIV_LAST);

  // Input capture and free-running PWM/fade timebase; only reset re-phases the divider.
  always_ff @(posedge clk) begin
    if (rst) begin
      colour_q_r <= 3'b000;
      enable_q_r <= 1'b0;
      pwm_cnt_r  <= {PWM_WIDTH{1'b0}};
      div_cnt_r  <= {DIV_W{1'b0}};
    end else begin
      colour_q_r <= bus.colour;
      enable_q_r <= bus.enable;
      pwm_cnt_r  <= pwm_cnt_r + PWM_WIDTH'(1);
      div_cnt_r  <= tick_s ? {DIV_W{1'b0}} : (div_cnt_r + DIV_W'(1));
    end
  end

  pwm_channel #(.PWM_WIDTH(PWM_WIDTH)) u_red (
    .clk(clk), .rst(rst), .tick(tick_s),
    .target_on(chan_on(colour_q_r, enable_q_r, RED_BIT)),
    .pwm_cnt(pwm_cnt_r), .pin(led_r_s), .at_target(at_r_s)
  );

  pwm_channel #(.PWM_WIDTH(PWM_WIDTH)) u_green (
    .clk(clk), .rst(rst), .tick(tick_s),
    .target_on(chan_on(colour_q_r, enable_q_r, GREEN_BIT)),
    .pwm_cnt(pwm_cnt_r), .pin(led_g_s), .at_target(at_g_s)
  );

  pwm_channel #(.PWM_WIDTH(PWM_WIDTH)) u_blue (
    .clk(clk), .rst(rst), .tick(tick_s),
    .target_on(chan_on(colour_q_r, enable_q_r, BLUE_BIT)),
    .pwm_cnt(pwm_cnt_r), .pin(led_b_s), .at_target(at_b_s)
  );

  assign bus.led_r = led_r_s;
  assign bus.led_g = led_g_s;
  assign bus.led_b = led_b_s;
  assign bus.busy  = ~(at_r_s & at_g_s & at_b_s);

endmodule

// File: tb/tb_rgb_pwm_driver.sv
// Directed bench for rgb_pwm_driver: default build plus a PWM_WIDTH=4 / FADE_DIV=1 build.
module tb_rgb_pwm_driver;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst6 = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  rgb_pwm_driver_if bus ();
  rgb_pwm_driver_if bus6 ();

  rgb_pwm_driver dut (.clk(clk), .rst(rst), .bus(bus));
  rgb_pwm_driver #(.PWM_WIDTH(4), .FADE_DIV(1)) dut6 (.clk(clk), .rst(rst6), .bus(bus6));

  typedef struct {
    logic [2:0] colour;
    logic       enable;
    logic       exp_busy;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int cnt;
    int hi_r, hi_g, hi_b;
    int bad;

    bus.colour  = 3'b111;
    bus.enable  = 1'b1;
    bus6.colour = 3'b000;
    bus6.enable = 1'b0;

    // Scenario 1: reset held for two cycles with white requested.
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("rst_leds", int'({bus.led_r, bus.led_g, bus.led_b}), 0);
      chk("rst_busy", int'(bus.busy), 0);
      chk("rst_pwm_cnt", int'(dut.pwm_cnt_r), 0);
    end

    // Busy one cycle after each request; back to idle once target returns to off.
    bus.colour = 3'b000;
    bus.enable = 1'b0;
    rst = 1'b0;
    step();
    vecs[0] = '{3'b000, 1'b1, 1'b0};
    vecs[1] = '{3'b001, 1'b1, 1'b1};
    vecs[2] = '{3'b010, 1'b1, 1'b1};
    vecs[3] = '{3'b011, 1'b1, 1'b1};
    vecs[4] = '{3'b100, 1'b1, 1'b1};
    vecs[5] = '{3'b101, 1'b1, 1'b1};
    vecs[6] = '{3'b110, 1'b1, 1'b1};
    vecs[7] = '{3'b111, 1'b1, 1'b1};
    vecs[8] = '{3'b111, 1'b0, 1'b0};
    vecs[9] = '{3'b010, 1'b0, 1'b0};
    for (int v = 0; v < 10; v++) begin
      bus.colour = vecs[v].colour;
      bus.enable = vecs[v].enable;
      step();
      chk($sformatf("vec%0d_busy", v), int'(bus.busy), int'(vecs[v].exp_busy));
      bus.colour = 3'b000;
      bus.enable = 1'b0;
      repeat (8) step();
      chk($sformatf("vec%0d_settle", v), int'(bus.busy), 0);
    end

    // Scenario 2: blue ramp from reset; divider phase is fixed by reset.
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.colour = 3'b001;
    bus.enable = 1'b1;
    step();
    chk("ramp_busy_rise", int'(bus.busy), 1);
    chk("ramp_pwm_cnt", int'(dut.pwm_cnt_r), 1);
    cnt = 0; hi_r = 0; hi_g = 0;
    while (bus.busy && cnt < 1100) begin
      cnt++;
      hi_r += int'(bus.led_r);
      hi_g += int'(bus.led_g);
      step();
    end
    // Ticks land 4,8,.. edges after the sample edge's predecessor; duty 255 on tick 255.
    chk("ramp_busy_len", cnt, 1019);
    chk("ramp_duty_b", int'(dut.u_blue.duty_r), 255);
    hi_b = 0;
    for (int i = 0; i < 256; i++) begin
      hi_b += int'(bus.led_b);
      hi_r += int'(bus.led_r);
      hi_g += int'(bus.led_g);
      step();
    end
    chk("ramp_led_b_high", hi_b, 255);
    chk("ramp_led_rg_high", hi_r + hi_g, 0);

    // Scenario 3: reversal to green after blue reaches 100.
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.colour = 3'b001;
    cnt = 0;
    while (dut.u_blue.duty_r != 8'd100 && cnt < 600) begin
      cnt++;
      step();
    end
    chk("rev_reach_100", int'(dut.u_blue.duty_r), 100);
    bus.colour = 3'b010;
    bad = 0; cnt = 0;
    step();
    while (dut.u_blue.duty_r != 8'd0 && cnt < 600) begin
      if (int'(dut.u_blue.duty_r) + int'(dut.u_green.duty_r) != 100) bad++;
      cnt++;
      step();
    end
    chk("rev_lockstep_bad", bad, 0);
    chk("rev_green_at_b0", int'(dut.u_green.duty_r), 100);
    bad = 0; cnt = 0;
    while (dut.u_green.duty_r != 8'd255 && cnt < 1100) begin
      if (!bus.busy) bad++;
      cnt++;
      step();
    end
    chk("rev_busy_held_bad", bad, 0);
    chk("rev_green_full", int'(dut.u_green.duty_r), 255);
    chk("rev_busy_fall", int'(bus.busy), 0);

    // Scenario 4: white settled, then enable dropped.
    bus.colour = 3'b111;
    cnt = 0;
    step();
    while (bus.busy && cnt < 1200) begin
      cnt++;
      step();
    end
    chk("white_settled", int'({dut.u_red.duty_r == 8'd255, dut.u_green.duty_r == 8'd255,
                               dut.u_blue.duty_r == 8'd255}), 7);
    bus.enable = 1'b0;
    step();
    cnt = 0; bad = 0;
    while (bus.busy && cnt < 1100) begin
      if (dut.u_red.duty_r != dut.u_green.duty_r || dut.u_green.duty_r != dut.u_blue.duty_r) bad++;
      cnt++;
      step();
    end
    chk("fadeout_lockstep_bad", bad, 0);
    chk("fadeout_len_in_range", int'(cnt >= 1017 && cnt <= 1020), 1);
    chk("fadeout_duty_r", int'(dut.u_red.duty_r), 0);

    // Scenario 5: reset while green is rising through 128.
    bus.colour = 3'b010;
    bus.enable = 1'b1;
    cnt = 0;
    while (dut.u_green.duty_r != 8'd128 && cnt < 700) begin
      cnt++;
      step();
    end
    chk("mid_reach_128", int'(dut.u_green.duty_r), 128);
    rst = 1'b1;
    step();
    chk("mid_rst_duties", int'(dut.u_red.duty_r) + int'(dut.u_green.duty_r) + int'(dut.u_blue.duty_r), 0);
    chk("mid_rst_leds", int'({bus.led_r, bus.led_g, bus.led_b}), 0);
    chk("mid_rst_busy", int'(bus.busy), 0);
    rst = 1'b0;
    step();
    chk("mid_restart_busy", int'(bus.busy), 1);
    step();
    step();
    chk("mid_restart_duty0", int'(dut.u_green.duty_r), 0);
    step();
    chk("mid_restart_duty1", int'(dut.u_green.duty_r), 1);

    // Scenario 6: 4-bit PWM with a tick every cycle.
    step();
    chk("d6_rst_busy", int'(bus6.busy), 0);
    rst6 = 1'b0;
    bus6.colour = 3'b100;
    bus6.enable = 1'b1;
    step();
    chk("d6_busy_rise", int'(bus6.busy), 1);
    chk("d6_duty_a", int'(dut6.u_red.duty_r), 0);
    repeat (14) step();
    chk("d6_duty_14", int'(dut6.u_red.duty_r), 14);
    chk("d6_busy_14", int'(bus6.busy), 1);
    step();
    chk("d6_duty_15", int'(dut6.u_red.duty_r), 15);
    chk("d6_busy_15", int'(bus6.busy), 0);
    step();
    hi_r = 0;
    for (int i = 0; i < 16; i++) begin
      hi_r += int'(bus6.led_r);
      step();
    end
    chk("d6_led_r_high", hi_r, 15);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rgb_pwm_driver.md
# rgb_pwm_driver

Drives the three pins of an RGB LED from the 3-bit `colour` code produced by the button-stepped LED colour sequencer. Each channel is generated by PWM. On a code change, each channel's brightness ramps linearly to the new level instead of jumping. The block sits between the colour sequencer and the board LED pins and owns all brightness and timing behaviour of the LED.

## Interface
Parameters:
- `PWM_WIDTH`, default 8: width of the PWM counter and of each duty register. Full-scale duty is `MAX = 2**PWM_WIDTH-1`.
- `FADE_DIV`, default 4: clock cycles per fade step. Legal range is ≥1.

Ports:
- `clk`: in, 1 bit. Single clock; all state updates on its rising edge.
- `rst`: in, 1 bit. Reset is synchronous and active-high.
- `colour`: in, 3 bits. Colour code. Bit 2 = red, bit 1 = green, bit 0 = blue; a bit at 1 means that channel is on.
- `enable`: in, 1 bit. 1 = follow `colour`; 0 = all targets forced to 0 (fade out).
- `led_r`, `led_g`, `led_b`: out, 1 bit each. Registered PWM pin drives.
- `busy`: out, 1 bit. High while any channel duty differs from its target.

## Operation
- **Input capture.** `colour` and `enable` are registered every cycle into `colour_q` and `enable_q`.
- **Channel targets.** For each channel, `target_x = (enable_q && colour_q[x]) ? MAX : 0`.
  - All 8 codes are legal. 000 means all off; 111 means white.
- **PWM counter.** `pwm_cnt` is PWM_WIDTH bits and free-running, incrementing every cycle. It wraps from MAX to 0.
- **Fade divider.** `div_cnt` counts 0..FADE_DIV-1 and wraps. `tick` is asserted when `div_cnt == FADE_DIV-1`.
- **Fade step.** On a `tick` cycle, each `duty_x` moves one step toward `target_x`:
  - +1 if below target.
  - -1 if above target.
  - Unchanged if equal.
  - `duty_x` never overshoots the target and never wraps.
- **Target change mid-fade.** The ramp continues from the current `duty_x` toward the new target. The ramp does not restart, and `duty_x` is not reset.
- **Pin output.** `led_x <= (duty_x > pwm_cnt)`. Consequences:
  - Duty 0: pin always low.
  - Duty MAX: pin high for MAX of every 2**PWM_WIDTH cycles, i.e. low only when `pwm_cnt == MAX`.
- **busy.** `busy = |{duty_r != target_r, duty_g != target_g, duty_b != target_b}`. It is combinational from registers only.
- **Reset.** On `rst`, the following all clear to 0 on the same edge, so all outputs read 0 in the cycle after the reset edge:
  - `colour_q`, `enable_q`, `pwm_cnt`, `div_cnt`, all `duty_x`.
  - `led_r`, `led_g`, `led_b`, and hence `busy`.
- **Reset mid-fade.** All brightness drops to 0 immediately; no ramp down.

## Timing
- **busy latency.** A `colour` or `enable` change sampled at edge k updates the targets at edge k, so `busy` rises in the cycle following edge k.
- **First duty step.** Occurs at the first `tick` edge after k. That is between 1 and FADE_DIV edges later, depending on divider phase.
- **Full ramp length.** A full ramp (0→MAX or MAX→0) takes exactly MAX ticks, i.e. MAX·FADE_DIV cycles ± divider phase. With defaults: 255 ticks, 1020 cycles.
- **Pin latency.** `led_x` lags the `duty_x`/`pwm_cnt` comparison by one cycle (registered output).
- **busy fall.** `busy` falls in the cycle after the edge on which the last channel reaches its target.
- **Divider independence.** The divider runs continuously and is never re-phased by input changes. Only `rst` re-phases it.

## Structure
- **Shared package `led_pkg`:**
  - Colour bit index constants `RED_BIT=2`, `GREEN_BIT=1`, `BLUE_BIT=0`.
  - Default `PWM_WIDTH` and `FADE_DIV`.
  - Both `rgb_pwm_driver` and the colour sequencer use these constants.
- **Sub-module `pwm_channel`:**
  - Inputs: `clk`, `rst`, `tick`, target-on bit, shared `pwm_cnt`.
  - Contents: `duty` register, step logic, registered comparator.
  - Outputs: pin and `at_target`.
  - Instantiated three times.
- **Top level** holds the input registers, `pwm_cnt`, `div_cnt`, and the `busy` OR.

## Test plan
All scenarios use defaults unless stated.
1. **Reset.** Assert `rst` for 2 cycles with `colour=3'b111`, `enable=1` → all outputs 0 after the reset edge; `pwm_cnt` restarts at 0.
2. **Ramp up.** From reset, drive `colour=3'b001`, `enable=1`:
   - `busy` rises 1 cycle later and stays high for 1020±4 cycles.
   - `duty_b` ends at 255; `led_b` is then high 255 of every 256 cycles.
   - `led_r` and `led_g` never go high.
3. **Reversal mid-ramp.** After 100 ticks of a blue ramp-up, switch to `colour=3'b010`:
   - `duty_b` descends from 100 to 0 in 100 ticks.
   - `duty_g` simultaneously climbs 0→255.
   - `busy` stays high until green reaches 255.
4. **Enable low.** With settled `colour=3'b111`, drop `enable` → all three duties descend in lockstep to 0 over 255 ticks; `busy` then falls.
5. **Reset mid-fade.** Assert `rst` while `duty_g=128` and rising → all duties and pins read 0 in the cycle after the edge. After release, the ramp restarts from 0.
6. **FADE_DIV=1, PWM_WIDTH=4.** Drive `colour=3'b100` → `duty_r` reaches 15 exactly 15 cycles after the first tick; `led_r` is high 15 of every 16 cycles.
